// File: rtl/seq_state_stage_pkg.sv
// Shared definitions for the "101" sequence detector and the og stage that consumes its state.
// State encoding is fixed: og decodes q1/q0 directly.
package seq_state_stage_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S0 = 2'b00;
    localparam logic [STATE_W-1:0] S1 = 2'b01;
    localparam logic [STATE_W-1:0] S2 = 2'b10;
    localparam logic [STATE_W-1:0] S3 = 2'b11;

    // The Mealy output og derives from an aligned (state, bit) pair.
    function automatic logic og_z(input logic [STATE_W-1:0] state, input logic x);
        return (state == S2) && x;
    endfunction

endpackage

// File: rtl/seq_state_stage_next_state.sv
// Combinational next-state function of the "101" detector.
// Kept stand-alone so a reference model can reuse the exact transition table.
module seq_next_state
    import seq_state_stage_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic [STATE_W-1:0] state,
    input  logic               x,
    output logic [STATE_W-1:0] next_state
);

    always_comb begin
        next_state = S0;
        case (state)
            S0: next_state = x ? S1 : S0;
            S1: next_state = x ? S1 : S2;
            S2: next_state = x ? S3 : S0;
            // Overlapping mode keeps the trailing "10" of "1010" as a partial match.
            S3: next_state = x ? S1 : (OVERLAP ? S2 : S0);
            default: next_state = S0;
        endcase
    end

endmodule

// File: rtl/seq_state_stage.sv
// Upstream stage of the og Mealy generator: owns the detector state, presents registered
// (pre-transition state, bit) pairs to og one cycle later, and counts hits.
module seq_state_stage
    import seq_state_stage_pkg::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             x,
    input  logic             x_valid,
    output logic             q1,
    output logic             q0,
    output logic             x_o,
    output logic             out_valid,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               next_is_hit;

    seq_next_state #(
        .OVERLAP(OVERLAP)
    ) u_next_state (
        .state     (state),
        .x         (x),
        .next_state(next_state)
    );

    assign next_is_hit = (next_state == S3);

    // State and og operand pipeline; the operands carry the state from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S0;
            q1        <= 1'b0;
            q0        <= 1'b0;
            x_o       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= S0;
            out_valid <= 1'b0;
        end else if (x_valid) begin
            state     <= next_state;
            q1        <= state[1];
            q0        <= state[0];
            x_o       <= x;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Hit pulse and saturating counter; a clear drops the bit presented alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else if (clear) begin
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else if (x_valid) begin
            hit <= next_is_hit;
            if (next_is_hit && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_ONE;
            end
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_state_stage.sv
// Self-checking bench for seq_state_stage: three configurations share one input stream and are
// compared against a suffix-matching model of the "101" detector.
module tb_seq_state_stage;
    import seq_state_stage_pkg::*;

    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n, clear, x, x_valid;

    logic q1_a[3], q0_a[3], xo_a[3], ov_a[3], hit_a[3];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    logic [1:0] ns_st;
    logic       ns_x;
    logic [1:0] ns_ov, ns_nov;

    int checks = 0;
    int errors = 0;

    // Model: per configuration, the last few accepted bits since reset/clear (or last hit when
    // overlap is off) decide the state as the longest matched prefix of "101".
    bit         m_overlap[3] = '{1'b1, 1'b0, 1'b1};
    int         m_max[3]     = '{255, 255, 3};
    int         m_len[3];
    logic [2:0] m_bits[3];
    bit         m_just[3];
    logic [1:0] m_q[3];
    logic       m_xo[3], m_vld[3], m_hit[3];
    int         m_cnt[3];

    typedef struct {
        logic [1:0] st;
        logic       x;
        logic [1:0] exp_ov;
        logic [1:0] exp_nov;
    } ns_vec_t;

    ns_vec_t tbl[8];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    seq_state_stage #(.OVERLAP(1'b1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .x(x), .x_valid(x_valid),
        .q1(q1_a[0]), .q0(q0_a[0]), .x_o(xo_a[0]), .out_valid(ov_a[0]),
        .hit(hit_a[0]), .hit_cnt(cnt0)
    );

    seq_state_stage #(.OVERLAP(1'b0), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .x(x), .x_valid(x_valid),
        .q1(q1_a[1]), .q0(q0_a[1]), .x_o(xo_a[1]), .out_valid(ov_a[1]),
        .hit(hit_a[1]), .hit_cnt(cnt1)
    );

    seq_state_stage #(.OVERLAP(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .x(x), .x_valid(x_valid),
        .q1(q1_a[2]), .q0(q0_a[2]), .x_o(xo_a[2]), .out_valid(ov_a[2]),
        .hit(hit_a[2]), .hit_cnt(cnt2)
    );

    seq_next_state #(.OVERLAP(1'b1)) u_ns_ov  (.state(ns_st), .x(ns_x), .next_state(ns_ov));
    seq_next_state #(.OVERLAP(1'b0)) u_ns_nov (.state(ns_st), .x(ns_x), .next_state(ns_nov));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] suffix_state(input int len, input logic [2:0] bits);
        if (len >= 3 && bits == 3'b101) return 2'd3;
        if (len >= 2 && bits[1:0] == 2'b10) return 2'd2;
        if (len >= 1 && bits[0]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_len[i] = 0; m_bits[i] = '0; m_just[i] = 1'b0;
            m_q[i] = '0; m_xo[i] = 1'b0; m_vld[i] = 1'b0; m_hit[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input logic cl, input logic v, input logic xb);
        logic [1:0] pre, nxt;
        for (int i = 0; i < 3; i++) begin
            if (cl) begin
                m_len[i] = 0; m_bits[i] = '0; m_just[i] = 1'b0;
                m_vld[i] = 1'b0; m_hit[i] = 1'b0; m_cnt[i] = 0;
            end else if (v) begin
                pre = suffix_state(m_len[i], m_bits[i]);
                if (!m_overlap[i] && m_just[i]) begin
                    m_len[i] = 0;
                    m_bits[i] = '0;
                end
                m_bits[i] = {m_bits[i][1:0], xb};
                if (m_len[i] < 3) m_len[i]++;
                nxt = suffix_state(m_len[i], m_bits[i]);
                m_q[i] = pre; m_xo[i] = xb; m_vld[i] = 1'b1;
                m_hit[i] = (nxt == 2'd3);
                m_just[i] = m_hit[i];
                if (m_hit[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end else begin
                m_vld[i] = 1'b0; m_hit[i] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        logic [7:0] ac;
        for (int i = 0; i < 3; i++) begin
            ac = (i == 0) ? cnt0 : (i == 1) ? cnt1 : {6'b0, cnt2};
            check($sformatf("dut%0d.state_pair", i), {q1_a[i], q0_a[i]}, m_q[i]);
            check($sformatf("dut%0d.x_o", i), xo_a[i], m_xo[i]);
            check($sformatf("dut%0d.out_valid", i), ov_a[i], m_vld[i]);
            check($sformatf("dut%0d.hit", i), hit_a[i], m_hit[i]);
            check($sformatf("dut%0d.hit_cnt", i), ac, m_cnt[i]);
            if (m_vld[i]) check($sformatf("dut%0d.og_z", i), og_z({q1_a[i], q0_a[i]}, xo_a[i]), m_hit[i]);
        end
    endtask

    task automatic applyStimulus(input logic xb, input logic v, input logic cl);
        x = xb; x_valid = v; clear = cl;
        @(posedge clk);
        model_edge(cl, v, xb);
        #1;
        checkOutput();
    endtask

    logic [2:0] exp_seq[5];
    logic [1:0] exp_sat[5];
    int hit_idx;

    initial begin
        tbl[0] = '{2'b00, 1'b0, 2'b00, 2'b00};
        tbl[1] = '{2'b00, 1'b1, 2'b01, 2'b01};
        tbl[2] = '{2'b01, 1'b0, 2'b10, 2'b10};
        tbl[3] = '{2'b01, 1'b1, 2'b01, 2'b01};
        tbl[4] = '{2'b10, 1'b0, 2'b00, 2'b00};
        tbl[5] = '{2'b10, 1'b1, 2'b11, 2'b11};
        tbl[6] = '{2'b11, 1'b0, 2'b10, 2'b00};
        tbl[7] = '{2'b11, 1'b1, 2'b01, 2'b01};
        exp_seq = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b101};
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; clear = 1'b0; x = 1'b0; x_valid = 1'b0;
        ns_st = 2'b00; ns_x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ns_st = tbl[i].st; ns_x = tbl[i].x;
            #1;
            check($sformatf("next_ov[%0d]", i), ns_ov, tbl[i].exp_ov);
            check($sformatf("next_nov[%0d]", i), ns_nov, tbl[i].exp_nov);
        end

        // 1,0,1,0,1 back to back from S0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(exp_seq[i][0], 1'b1, 1'b0);
            check($sformatf("stream_pair[%0d]", i), {q1_a[0], q0_a[0], xo_a[0]}, exp_seq[i]);
        end
        check("stream_cnt_ov", cnt0, 8'd2);
        check("stream_cnt_nov", cnt1, 8'd1);
        check("nov_state_after_bit4", {q1_a[1], q0_a[1]}, 2'b00);

        // Gapped 1,0,1.
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            applyStimulus((b != 1), 1'b1, 1'b0);
            if (b < 2) repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        check("gap_hit", hit_a[0], 1'b1);

        // Saturation of the 2-bit counter over five hits.
        applyStimulus(1'b0, 1'b0, 1'b1);
        hit_idx = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(((i % 2) == 0), 1'b1, 1'b0);
            if (i >= 2 && (i % 2) == 0) begin
                check($sformatf("sat_hit[%0d]", hit_idx), hit_a[2], 1'b1);
                check($sformatf("sat_cnt[%0d]", hit_idx), cnt2, exp_sat[hit_idx]);
                hit_idx++;
            end
        end

        // clear together with a completing bit while in S2.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        check("clr_hit", hit_a[0], 1'b0);
        check("clr_valid", ov_a[0], 1'b0);
        check("clr_cnt", cnt0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        check("clr_then_s0", {q1_a[0], q0_a[0]}, 2'b00);

        // Asynchronous reset with the clock stopped, mid-match.
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput();
        #3;
        rst_n = 1'b1;
        clk_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        check("post_reset_from_s0", {q1_a[0], q0_a[0]}, 2'b00);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
